// File: rtl/branch_seq_ctrl.sv
// branch_seq_ctrl: Moore sequencer for fetch, ldi and conditional-branch microsteps
module branch_seq_ctrl (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        stop,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        incPC,
  output logic        e_PC,
  output logic        e_IR,
  output logic        e_Y,
  output logic        e_Z,
  output logic        e_MAR,
  output logic        e_MDR,
  output logic        MDR_read,
  output logic        ram_read,
  output logic        e_CON_FF,
  output logic        Gra,
  output logic        Grb,
  output logic        e_Rin,
  output logic        e_Rout,
  output logic        BAout,
  output logic        imm_sel,
  output logic [4:0]  BusDataSelect,
  output logic [3:0]  ALU_op,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic        instr_done
);
  localparam logic [4:0] PC_OUT  = 5'b10100;
  localparam logic [4:0] MDR_OUT = 5'b10101;
  localparam logic [4:0] ZLO_OUT = 5'b10011;
  localparam logic [4:0] C_OUT   = 5'b11000;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [4:0] OP_LDI  = 5'b01000;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // HALT is the entry cycle (pulses instr_done); HALT_W is the parked state after it
  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_F3, S_DEC,
    S_L3, S_L4, S_L5, S_B3, S_B4, S_B5, S_B6,
    S_END, S_HALT, S_HALT_W
  } state_t;

  state_t state, next_state;
  logic [4:0] op;
  logic legal;
  logic unused_ir;

  assign op = ir[31:27];
  assign legal = (op == OP_LDI) || (op == OP_BR) || (op == OP_NOP) || (op == OP_HALT);
  assign unused_ir = ^ir[26:0];
  assign busy = !(state inside {S_IDLE, S_HALT, S_HALT_W});

  // state register, forced to IDLE asynchronously by clear
  always_ff @(posedge clock or posedge clear)
    if (clear) state <= S_IDLE;
    else state <= next_state;

  // sticky unsupported-opcode flag, raised when DEC sees an unknown opcode
  always_ff @(posedge clock or posedge clear)
    if (clear) illegal <= 1'b0;
    else if (state == S_DEC && !legal) illegal <= 1'b1;

  // next-state sequencing; run only matters in IDLE, stop only in END
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   next_state = run ? S_F0 : S_IDLE;
      S_F0:     next_state = S_F1;
      S_F1:     next_state = S_F2;
      S_F2:     next_state = S_F3;
      S_F3:     next_state = S_DEC;
      S_DEC:    next_state = (op == OP_LDI)  ? S_L3 :
                             (op == OP_BR)   ? S_B3 :
                             (op == OP_HALT) ? S_HALT : S_END;
      S_L3:     next_state = S_L4;
      S_L4:     next_state = S_L5;
      S_L5:     next_state = S_END;
      S_B3:     next_state = S_B4;
      S_B4:     next_state = S_B5;
      S_B5:     next_state = S_B6;
      S_B6:     next_state = S_END;
      S_END:    next_state = stop ? S_IDLE : S_F0;
      S_HALT:   next_state = S_HALT_W;
      S_HALT_W: next_state = S_HALT_W;
      default:  next_state = S_IDLE;
    endcase
  end

  // Moore strobe decode; e_PC in B6 follows con_ff so a taken branch loads the target
  always_comb begin
    incPC = 1'b0;
    e_PC = 1'b0;
    e_IR = 1'b0;
    e_Y = 1'b0;
    e_Z = 1'b0;
    e_MAR = 1'b0;
    e_MDR = 1'b0;
    MDR_read = 1'b0;
    ram_read = 1'b0;
    e_CON_FF = 1'b0;
    Gra = 1'b0;
    Grb = 1'b0;
    e_Rin = 1'b0;
    e_Rout = 1'b0;
    BAout = 1'b0;
    imm_sel = 1'b0;
    BusDataSelect = 5'b00000;
    ALU_op = 4'b0000;
    halted = 1'b0;
    instr_done = 1'b0;
    case (state)
      S_F0:     begin BusDataSelect = PC_OUT; e_MAR = 1'b1; incPC = 1'b1; end
      S_F1:     ram_read = 1'b1;
      S_F2:     begin MDR_read = 1'b1; e_MDR = 1'b1; end
      S_F3:     begin BusDataSelect = MDR_OUT; e_IR = 1'b1; end
      S_L3:     begin Grb = 1'b1; BAout = 1'b1; e_Y = 1'b1; end
      S_L4:     begin imm_sel = 1'b1; ALU_op = ALU_ADD; e_Z = 1'b1; end
      S_L5:     begin BusDataSelect = ZLO_OUT; Gra = 1'b1; e_Rin = 1'b1; end
      S_B3:     begin Gra = 1'b1; e_Rout = 1'b1; e_CON_FF = 1'b1; end
      S_B4:     begin BusDataSelect = PC_OUT; e_Y = 1'b1; end
      S_B5:     begin BusDataSelect = C_OUT; imm_sel = 1'b1; ALU_op = ALU_ADD; e_Z = 1'b1; end
      S_B6:     begin BusDataSelect = ZLO_OUT; e_PC = con_ff; end
      S_END:    instr_done = 1'b1;
      S_HALT:   begin halted = 1'b1; instr_done = 1'b1; end
      S_HALT_W: halted = 1'b1;
      default:  ;
    endcase
  end
endmodule

// File: tb/tb_branch_seq_ctrl.sv
// tb_branch_seq_ctrl: randomized check of branch_seq_ctrl against a cycle-count reference model
module tb_branch_seq_ctrl;
  logic clock, clear, run, stop, con_ff;
  logic [31:0] ir;
  logic incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, MDR_read, ram_read, e_CON_FF;
  logic Gra, Grb, e_Rin, e_Rout, BAout, imm_sel;
  logic [4:0] BusDataSelect;
  logic [3:0] ALU_op;
  logic busy, halted, illegal, instr_done;
  int total = 0, bad = 0;

  branch_seq_ctrl dut (
    .clock(clock), .clear(clear), .run(run), .stop(stop), .ir(ir), .con_ff(con_ff),
    .incPC(incPC), .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_MAR(e_MAR),
    .e_MDR(e_MDR), .MDR_read(MDR_read), .ram_read(ram_read), .e_CON_FF(e_CON_FF),
    .Gra(Gra), .Grb(Grb), .e_Rin(e_Rin), .e_Rout(e_Rout), .BAout(BAout), .imm_sel(imm_sel),
    .BusDataSelect(BusDataSelect), .ALU_op(ALU_op), .busy(busy), .halted(halted),
    .illegal(illegal), .instr_done(instr_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam int INC = 15, EPC = 14, EIR = 13, EY = 12, EZ = 11, EMAR = 10, EMDR = 9, MDRR = 8;
  localparam int RAMR = 7, ECON = 6, GRA = 5, GRB = 4, ERIN = 3, EROUT = 2, BAO = 1, IMM = 0;

  // model: mode 0 idle, 1 running (pos = cycles since F0), 2 halted; kind 0 ldi, 1 branch, 2 nop/illegal
  int mode, pos, kind, last;
  bit hfirst, m_ill;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t mode=%0d pos=%0d got=%h exp=%h", tag, $time, mode, pos, got, exp);
    end
  endtask

  function automatic logic [28:0] expv();
    logic [15:0] s;
    logic [4:0] b;
    logic [3:0] a;
    logic done;
    s = '0; b = '0; a = '0;
    done = (mode == 1 && pos >= 5 && pos == last) || (mode == 2 && hfirst);
    if (mode == 1) begin
      if (pos == 0) begin b = 5'b10100; s[EMAR] = 1; s[INC] = 1; end
      if (pos == 1) s[RAMR] = 1;
      if (pos == 2) begin s[MDRR] = 1; s[EMDR] = 1; end
      if (pos == 3) begin b = 5'b10101; s[EIR] = 1; end
      if (kind == 0 && pos == 5) begin s[GRB] = 1; s[BAO] = 1; s[EY] = 1; end
      if (kind == 0 && pos == 6) begin s[IMM] = 1; a = 4'b0011; s[EZ] = 1; end
      if (kind == 0 && pos == 7) begin b = 5'b10011; s[GRA] = 1; s[ERIN] = 1; end
      if (kind == 1 && pos == 5) begin s[GRA] = 1; s[EROUT] = 1; s[ECON] = 1; end
      if (kind == 1 && pos == 6) begin b = 5'b10100; s[EY] = 1; end
      if (kind == 1 && pos == 7) begin b = 5'b11000; s[IMM] = 1; a = 4'b0011; s[EZ] = 1; end
      if (kind == 1 && pos == 8) begin b = 5'b10011; s[EPC] = con_ff; end
    end
    return {s, b, a, mode == 1, mode == 2, m_ill, done};
  endfunction

  function automatic logic [28:0] gotv();
    return {incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, MDR_read, ram_read, e_CON_FF,
            Gra, Grb, e_Rin, e_Rout, BAout, imm_sel, BusDataSelect, ALU_op,
            busy, halted, illegal, instr_done};
  endfunction

  task automatic model_reset();
    mode = 0; pos = 0; kind = 2; last = 5; hfirst = 0; m_ill = 0;
  endtask

  task automatic model_step();
    logic [4:0] op;
    op = ir[31:27];
    if (mode == 0) begin
      if (run) begin mode = 1; pos = 0; end
    end else if (mode == 1) begin
      if (pos == 4) begin
        if (op == 5'b01000) begin kind = 0; last = 8; end
        else if (op == 5'b10010) begin kind = 1; last = 9; end
        else if (op == 5'b11011) begin mode = 2; hfirst = 1; end
        else begin kind = 2; last = 5; if (op != 5'b11010) m_ill = 1; end
        pos++;
      end else if (pos > 4 && pos == last) begin
        mode = stop ? 0 : 1;
        pos = 0;
      end else pos++;
    end else hfirst = 0;
  endtask

  initial begin
    logic [31:0] r;
    int sel;
    clear = 1; run = 0; stop = 0; con_ff = 0; ir = 32'h42000078;
    model_reset();
    #3;
    chk("reset", {3'b0, gotv()}, {3'b0, expv()});
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      clear = clear ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 59) == 0);
      run = ($urandom_range(0, 3) != 0);
      stop = ($urandom_range(0, 3) == 0);
      con_ff = $urandom_range(0, 1) == 1;
      if (pos == 3 || $urandom_range(0, 7) == 0) begin
        r = $urandom;
        sel = $urandom_range(0, 15);
        r[31:27] = sel < 5 ? 5'b01000 : sel < 10 ? 5'b10010 : sel < 12 ? 5'b11010 :
                   sel == 12 ? 5'b11011 : 5'($urandom_range(0, 31));
        ir = r;
      end
      if (clear) model_reset();
      #1;
      chk(clear ? "clear" : "outs", {3'b0, gotv()}, {3'b0, expv()});
      @(posedge clock);
      if (!clear) model_step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
